gpc_bus_initiator: RTL and testbench
====================================

// Module: gpc_bus_initiator
// PURPOSE
// - Initiator side of the counter register bus (acc_en/wr_en/addr/wdata/rdata).
// - Takes one command at a time on a valid/ready port and turns it into a single-cycle register access.
// - Returns a response on a valid/ready port. Reads can poll a register until a masked value matches.
// - Sits between a host/sequencer and the counter top-level; lets software-style sequences program the counter.
// PARAMETERS
// - READ_LATENCY  1    cycles from the access cycle to the rdata_i sample (0 = sample in the access cycle)
// - POLL_MAX      255  maximum read attempts in one poll command before timeout (>=1)
// - POLL_GAP      4    idle cycles between poll attempts (>=0)
// PORTS
// - clk_i         in   1   clock; all logic is on the rising edge
// - rstn_i        in   1   asynchronous active-low reset
// - cmd_valid_i   in   1   command valid
// - cmd_ready_o   out  1   command ready; high only in IDLE
// - cmd_write_i   in   1   1 = write, 0 = read
// - cmd_poll_i    in   1   read only: poll until (rdata & mask) == (wdata & mask)
// - cmd_addr_i    in   3   register address
// - cmd_wdata_i   in   16  write data, or poll expected value
// - cmd_mask_i    in   16  poll compare mask
// - rsp_valid_o   out  1   response valid; held until rsp_ready_i
// - rsp_ready_i   in   1   response accepted
// - rsp_rdata_o   out  16  last sampled read data (0 for writes)
// - rsp_timeout_o out  1   poll ended without a match
// - acc_en_o      out  1   bus access strobe, exactly 1 cycle per attempt
// - wr_en_o       out  1   bus write qualifier; valid only with acc_en_o
// - addr_o        out  3   bus address
// - wdata_o       out  16  bus write data
// - rdata_i       in   16  bus read data
// - busy_o        out  1   state != IDLE
// BEHAVIOUR
// - Reset values: state IDLE; cmd_ready_o=1; all other outputs 0; internal counters 0.
// - States: IDLE, ACCESS, WAIT, GAP, RESP.
// - IDLE: on cmd_valid_i && cmd_ready_o, latch all cmd fields and go to ACCESS.
//   cmd_poll_i is ignored when cmd_write_i=1.
// - ACCESS (1 cycle): acc_en_o=1; wr_en_o=latched write; addr_o/wdata_o=latched values.
//   - Write: next state RESP.
//   - Read, READ_LATENCY=0: sample rdata_i at the end of this cycle.
//   - Read, READ_LATENCY>0: go to WAIT.
// - WAIT: count READ_LATENCY-1 further cycles; sample rdata_i on the edge that ends the
//   READ_LATENCY-th cycle after ACCESS.
// - After a sample, non-poll read: RESP.
// - After a sample, poll: if the masked values match, RESP with timeout=0. Else increment
//   the attempt count; if it equals POLL_MAX, RESP with timeout=1; else GAP.
// - GAP: POLL_GAP cycles with acc_en_o=0, then ACCESS. POLL_GAP=0 goes straight to ACCESS.
// - RESP: rsp_valid_o=1 with rsp_rdata_o/rsp_timeout_o stable; on rsp_ready_i go to IDLE
//   and clear rsp_valid_o next cycle.
// - Latency:
//   - acc_en_o rises the cycle after command accept.
//   - Write: rsp_valid_o rises 1 cycle after ACCESS (3-cycle minimum command period).
//   - Read: rsp_valid_o rises READ_LATENCY+1 cycles after ACCESS.
// - Bus outputs: addr_o/wdata_o hold their last value outside ACCESS; wr_en_o=0 when acc_en_o=0.
// - Attempt counter is $clog2(POLL_MAX+1) bits; it resets to 0 on each command accept and never wraps.
// - Mask 0 on a poll: first attempt matches and the response returns with timeout=0.
// - A new cmd_valid_i while busy is not accepted; the command must be held until cmd_ready_o.
// - Reset mid-operation: immediate return to reset values; in-flight command dropped, no response.
// STRUCTURE
// - gpc_pkg holds the shared definitions:
//   - ADDR_W=3, DATA_W=16
//   - register address constants (ctrl, duty, target, capture, count, status)
//   - state encoding localparams
// - Single module: FSM, latency/gap down-counter and attempt counter are inline; no sub-module.
// TESTING
// - Write addr 3'd2 data 16'h0155 -> one acc_en_o pulse with wr_en_o=1, addr_o=2, wdata_o=16'h0155;
//   rsp_valid_o 1 cycle later, rdata=0.
// - Read addr 3'd5, rdata_i=16'hA5A5, READ_LATENCY=1 -> rsp_rdata_o=16'hA5A5 two cycles after ACCESS.
// - Poll addr 5, mask 16'h0001, expect 16'h0001; rdata bit0 goes 1 on attempt 3
//   -> exactly 3 acc_en_o pulses spaced POLL_GAP+READ_LATENCY+1 cycles, timeout=0.
// - Poll with POLL_MAX=4, never matching -> 4 pulses, rsp_timeout_o=1.
// - rsp_ready_i held low 10 cycles -> rsp_valid_o and data stable; cmd_ready_o stays 0; no bus pulse.
// - rstn_i asserted in WAIT -> all outputs 0 on that edge, cmd_ready_o=1 after release, no response.

Source files
------------

// File: rtl/gpc_pkg.sv
// Shared definitions for the counter register bus: widths, register map
// and the bus initiator state encoding.
package gpc_pkg;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 16;

   localparam logic [ADDR_W-1:0] ADDR_CTRL    = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_DUTY    = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_TARGET  = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_CAPTURE = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_COUNT   = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd5;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ACCESS = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_GAP    = 3'd3;
   localparam logic [2:0] ST_RESP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      ACCESS = ST_ACCESS,
      WAIT   = ST_WAIT,
      GAP    = ST_GAP,
      RESP   = ST_RESP
   } init_state_e;

   // A zero mask bit means "don't care", so mask 0 always matches.
   function automatic logic poll_hit(input logic [DATA_W-1:0] rdata,
                                     input logic [DATA_W-1:0] expect_val,
                                     input logic [DATA_W-1:0] mask);
      return ((rdata ^ expect_val) & mask) == '0;
   endfunction

endpackage

// File: rtl/gpc_bus_initiator.sv
// Bus initiator for the counter register bus: one command at a time becomes a
// single-cycle register access, with optional masked polling of a register.
module gpc_bus_initiator
   import gpc_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int POLL_MAX     = 255,
   parameter int POLL_GAP     = 4
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic              cmd_poll_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   input  logic [DATA_W-1:0] cmd_mask_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_timeout_o,
   output logic              acc_en_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] wdata_o,
   input  logic [DATA_W-1:0] rdata_i,
   output logic              busy_o
);

   localparam int ATT_W   = (POLL_MAX < 1) ? 1 : $clog2(POLL_MAX + 1);
   localparam int CNT_MAX = (READ_LATENCY > POLL_GAP) ? READ_LATENCY : POLL_GAP;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
   localparam logic [ATT_W-1:0] ATT_LAST  = ATT_W'((POLL_MAX > 0) ? POLL_MAX - 1 : 0);

   init_state_e       state;
   logic              write_q;
   logic              poll_q;
   logic [DATA_W-1:0] mask_q;
   logic [CNT_W-1:0]  cnt;
   logic [ATT_W-1:0]  attempt_cnt;
   logic              sample_now;
   logic              hit;

   // rdata_i is captured either at the end of ACCESS (zero latency) or when
   // the latency countdown in WAIT expires.
   always_comb begin
      sample_now = 1'b0;
      if (state == WAIT && cnt == '0)
         sample_now = 1'b1;
      if (state == ACCESS && !write_q && READ_LATENCY == 0)
         sample_now = 1'b1;
   end

   // wdata_o keeps the latched command data, so it doubles as the poll expect value.
   assign hit = poll_hit(rdata_i, wdata_o, mask_q);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state         <= IDLE;
         cmd_ready_o   <= 1'b1;
         busy_o        <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_timeout_o <= 1'b0;
         acc_en_o      <= 1'b0;
         wr_en_o       <= 1'b0;
         addr_o        <= '0;
         wdata_o       <= '0;
         write_q       <= 1'b0;
         poll_q        <= 1'b0;
         mask_q        <= '0;
         cnt           <= '0;
         attempt_cnt   <= '0;
      end else begin
         acc_en_o <= 1'b0;
         wr_en_o  <= 1'b0;

         case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  state         <= ACCESS;
                  acc_en_o      <= 1'b1;
                  wr_en_o       <= cmd_write_i;
                  addr_o        <= cmd_addr_i;
                  wdata_o       <= cmd_wdata_i;
                  mask_q        <= cmd_mask_i;
                  write_q       <= cmd_write_i;
                  poll_q        <= cmd_poll_i & ~cmd_write_i;
                  attempt_cnt   <= '0;
                  rsp_rdata_o   <= '0;
                  rsp_timeout_o <= 1'b0;
                  cmd_ready_o   <= 1'b0;
                  busy_o        <= 1'b1;
               end
            end
            ACCESS: begin
               if (write_q) begin
                  state       <= RESP;
                  rsp_valid_o <= 1'b1;
               end else if (READ_LATENCY != 0) begin
                  state <= WAIT;
                  cnt   <= LAT_LOAD;
               end
            end
            WAIT: begin
               if (cnt != '0)
                  cnt <= cnt - 1'b1;
            end
            GAP: begin
               if (cnt == '0) begin
                  state    <= ACCESS;
                  acc_en_o <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state       <= IDLE;
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  busy_o      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         // A sample overrides the per-state decisions above: it ends the attempt.
         if (sample_now) begin
            rsp_rdata_o <= rdata_i;
            if (!poll_q || hit) begin
               state       <= RESP;
               rsp_valid_o <= 1'b1;
            end else begin
               attempt_cnt <= attempt_cnt + 1'b1;
               if (attempt_cnt == ATT_LAST) begin
                  state         <= RESP;
                  rsp_valid_o   <= 1'b1;
                  rsp_timeout_o <= 1'b1;
               end else if (POLL_GAP == 0) begin
                  state    <= ACCESS;
                  acc_en_o <= 1'b1;
               end else begin
                  state <= GAP;
                  cnt   <= GAP_LOAD;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_gpc_bus_initiator.sv
// Directed bench for gpc_bus_initiator: writes, reads, polling with match and
// timeout, response backpressure and reset while a read is in flight.
module tb_gpc_bus_initiator;
   import gpc_pkg::*;

   logic              clk_i = 1'b0;
   logic              rstn_i = 1'b0;
   logic              cmd_valid_i = 1'b0;
   logic              cmd_ready_o;
   logic              cmd_write_i = 1'b0;
   logic              cmd_poll_i = 1'b0;
   logic [ADDR_W-1:0] cmd_addr_i = '0;
   logic [DATA_W-1:0] cmd_wdata_i = '0;
   logic [DATA_W-1:0] cmd_mask_i = '0;
   logic              rsp_valid_o;
   logic              rsp_ready_i = 1'b0;
   logic [DATA_W-1:0] rsp_rdata_o;
   logic              rsp_timeout_o;
   logic              acc_en_o;
   logic              wr_en_o;
   logic [ADDR_W-1:0] addr_o;
   logic [DATA_W-1:0] wdata_o;
   logic [DATA_W-1:0] rdata_i;
   logic              busy_o;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int pulse_cyc [64];
   int bad_wr = 0;
   int bad_width = 0;
   logic acc_prev = 1'b0;
   logic [DATA_W-1:0] base_rdata = '0;
   int match_at = 0;
   int c;
   int p0;
   int p1;

   gpc_bus_initiator #(
      .READ_LATENCY (1),
      .POLL_MAX     (4),
      .POLL_GAP     (2)
   ) dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_write_i   (cmd_write_i),
      .cmd_poll_i    (cmd_poll_i),
      .cmd_addr_i    (cmd_addr_i),
      .cmd_wdata_i   (cmd_wdata_i),
      .cmd_mask_i    (cmd_mask_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_timeout_o (rsp_timeout_o),
      .acc_en_o      (acc_en_o),
      .wr_en_o       (wr_en_o),
      .addr_o        (addr_o),
      .wdata_o       (wdata_o),
      .rdata_i       (rdata_i),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Register model: bit0 comes up once the bus has seen match_at pulses.
   assign rdata_i = (match_at != 0 && pulse_cnt >= match_at) ? 16'h0001 : base_rdata;

   // Bus monitor: pulse count/timestamps and strobe protocol violations.
   always @(posedge clk_i) begin
      cyc      <= cyc + 1;
      acc_prev <= acc_en_o;
      if (acc_en_o) begin
         pulse_cnt <= pulse_cnt + 1;
         pulse_cyc[(pulse_cnt + 1) % 64] <= cyc;
      end
      if (wr_en_o && !acc_en_o)
         bad_wr <= bad_wr + 1;
      if (acc_en_o && acc_prev)
         bad_width <= bad_width + 1;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Called at a negedge; returns at the negedge inside the ACCESS cycle.
   task automatic applyStimulus(input logic wr, input logic poll, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] mask);
      int waited = 0;
      cmd_write_i = wr;
      cmd_poll_i  = poll;
      cmd_addr_i  = addr;
      cmd_wdata_i = wdata;
      cmd_mask_i  = mask;
      cmd_valid_i = 1'b1;
      while (!cmd_ready_o && waited < 20) begin
         @(negedge clk_i);
         waited++;
      end
      checkOutput("cmd_accept", {31'd0, cmd_ready_o}, 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
   endtask

   task automatic waitRsp(input int maxc, output int cycles);
      cycles = 0;
      while (!rsp_valid_o && cycles < maxc) begin
         @(negedge clk_i);
         cycles++;
      end
      checkOutput("rsp_arrived", {31'd0, rsp_valid_o}, 32'd1);
   endtask

   task automatic finishRsp();
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      checkOutput("rsp_dropped", {31'd0, rsp_valid_o}, 32'd0);
      checkOutput("ready_back", {31'd0, cmd_ready_o}, 32'd1);
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      checkOutput("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
      checkOutput("rst_acc_en", {31'd0, acc_en_o}, 32'd0);
      checkOutput("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
      checkOutput("rst_addr", {29'd0, addr_o}, 32'd0);
      checkOutput("rst_wdata", {16'd0, wdata_o}, 32'd0);
      rstn_i = 1'b1;
      @(negedge clk_i);

      $display("[TB] write target 0x0155");
      p0 = pulse_cnt;
      applyStimulus(1'b1, 1'b0, ADDR_TARGET, 16'h0155, 16'h0000);
      checkOutput("wr_acc_en", {31'd0, acc_en_o}, 32'd1);
      checkOutput("wr_wr_en", {31'd0, wr_en_o}, 32'd1);
      checkOutput("wr_addr", {29'd0, addr_o}, 32'd2);
      checkOutput("wr_wdata", {16'd0, wdata_o}, 32'h0155);
      checkOutput("wr_busy", {31'd0, busy_o}, 32'd1);
      checkOutput("wr_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
      waitRsp(20, c);
      checkOutput("wr_rsp_latency", c, 32'd1);
      checkOutput("wr_rdata", {16'd0, rsp_rdata_o}, 32'd0);
      checkOutput("wr_timeout", {31'd0, rsp_timeout_o}, 32'd0);
      checkOutput("wr_pulses", pulse_cnt - p0, 32'd1);
      finishRsp();

      $display("[TB] read status");
      base_rdata = 16'hA5A5;
      applyStimulus(1'b0, 1'b0, ADDR_STATUS, 16'h0000, 16'h0000);
      checkOutput("rd_acc_en", {31'd0, acc_en_o}, 32'd1);
      checkOutput("rd_wr_en", {31'd0, wr_en_o}, 32'd0);
      checkOutput("rd_addr", {29'd0, addr_o}, 32'd5);
      waitRsp(20, c);
      checkOutput("rd_rsp_latency", c, 32'd2);
      checkOutput("rd_rdata", {16'd0, rsp_rdata_o}, 32'hA5A5);
      finishRsp();

      $display("[TB] poll status bit0, matches on third attempt");
      p0 = pulse_cnt;
      match_at = p0 + 3;
      base_rdata = 16'h0000;
      applyStimulus(1'b0, 1'b1, ADDR_STATUS, 16'h0001, 16'h0001);
      waitRsp(100, c);
      checkOutput("poll_latency", c, 32'd10);
      checkOutput("poll_pulses", pulse_cnt - p0, 32'd3);
      checkOutput("poll_gap_1_2", pulse_cyc[(p0 + 2) % 64] - pulse_cyc[(p0 + 1) % 64], 32'd4);
      checkOutput("poll_gap_2_3", pulse_cyc[(p0 + 3) % 64] - pulse_cyc[(p0 + 2) % 64], 32'd4);
      checkOutput("poll_timeout", {31'd0, rsp_timeout_o}, 32'd0);
      checkOutput("poll_rdata", {16'd0, rsp_rdata_o}, 32'h0001);
      match_at = 0;
      finishRsp();

      $display("[TB] poll count, never matches");
      p0 = pulse_cnt;
      applyStimulus(1'b0, 1'b1, ADDR_COUNT, 16'h1234, 16'hFFFF);
      waitRsp(100, c);
      checkOutput("to_latency", c, 32'd14);
      checkOutput("to_pulses", pulse_cnt - p0, 32'd4);
      checkOutput("to_timeout", {31'd0, rsp_timeout_o}, 32'd1);
      checkOutput("to_rdata", {16'd0, rsp_rdata_o}, 32'h0000);
      finishRsp();

      $display("[TB] poll with zero mask");
      p0 = pulse_cnt;
      base_rdata = 16'hBEEF;
      applyStimulus(1'b0, 1'b1, ADDR_CAPTURE, 16'h1234, 16'h0000);
      waitRsp(20, c);
      checkOutput("m0_latency", c, 32'd2);
      checkOutput("m0_pulses", pulse_cnt - p0, 32'd1);
      checkOutput("m0_timeout", {31'd0, rsp_timeout_o}, 32'd0);
      checkOutput("m0_rdata", {16'd0, rsp_rdata_o}, 32'hBEEF);
      finishRsp();

      $display("[TB] response backpressure with a pending command");
      base_rdata = 16'h5A5A;
      applyStimulus(1'b0, 1'b0, ADDR_CAPTURE, 16'h0000, 16'h0000);
      waitRsp(20, c);
      p1 = pulse_cnt;
      cmd_write_i = 1'b1;
      cmd_poll_i  = 1'b0;
      cmd_addr_i  = ADDR_DUTY;
      cmd_wdata_i = 16'h0007;
      cmd_valid_i = 1'b1;
      base_rdata  = 16'h0000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         checkOutput("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
         checkOutput("hold_rdata", {16'd0, rsp_rdata_o}, 32'h5A5A);
         checkOutput("hold_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
      end
      checkOutput("hold_no_pulse", pulse_cnt - p1, 32'd0);
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      checkOutput("hold_released", {31'd0, rsp_valid_o}, 32'd0);
      checkOutput("hold_ready_back", {31'd0, cmd_ready_o}, 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      checkOutput("pend_acc_en", {31'd0, acc_en_o}, 32'd1);
      checkOutput("pend_wr_en", {31'd0, wr_en_o}, 32'd1);
      checkOutput("pend_addr", {29'd0, addr_o}, 32'd1);
      checkOutput("pend_wdata", {16'd0, wdata_o}, 32'h0007);
      waitRsp(20, c);
      checkOutput("pend_latency", c, 32'd1);
      finishRsp();

      $display("[TB] reset during read wait");
      base_rdata = 16'h1111;
      applyStimulus(1'b0, 1'b0, ADDR_COUNT, 16'h0000, 16'h0000);
      @(negedge clk_i);
      checkOutput("rw_busy", {31'd0, busy_o}, 32'd1);
      rstn_i = 1'b0;
      #1;
      checkOutput("rw_acc_en", {31'd0, acc_en_o}, 32'd0);
      checkOutput("rw_wr_en", {31'd0, wr_en_o}, 32'd0);
      checkOutput("rw_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      checkOutput("rw_busy_clr", {31'd0, busy_o}, 32'd0);
      checkOutput("rw_addr", {29'd0, addr_o}, 32'd0);
      checkOutput("rw_wdata", {16'd0, wdata_o}, 32'd0);
      checkOutput("rw_rdata", {16'd0, rsp_rdata_o}, 32'd0);
      checkOutput("rw_timeout", {31'd0, rsp_timeout_o}, 32'd0);
      checkOutput("rw_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
      p1 = pulse_cnt;
      repeat (2) @(negedge clk_i);
      rstn_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         checkOutput("rw_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      end
      checkOutput("rw_ready_after", {31'd0, cmd_ready_o}, 32'd1);
      checkOutput("rw_no_pulse", pulse_cnt - p1, 32'd0);

      checkOutput("wr_en_outside_acc", bad_wr, 32'd0);
      checkOutput("acc_en_width", bad_width, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
